// File: rtl/exp_2_ctrl_pkg.sv
// Shared definitions for the exp_2 softmax controller: FSM state encoding,
// accumulator guard width and element index width.
package exp_2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Extra accumulator headroom: up to 16 results, each below 1.0.
  localparam int SUM_GUARD_BITS = 4;

  // Width of out_index_o; supports vectors of up to 16 elements.
  localparam int IDX_W = 4;

endpackage

// File: rtl/exp_2_ctrl.sv
// exp_2_ctrl: sequences one softmax vector through an external exp_2
// datapath. Samples are forwarded one registered stage after acceptance,
// returning results are re-indexed, forwarded and summed, and the final sum
// is presented for one cycle in DONE.
// Optional feature: define EXP_2_CTRL_TIMEOUT_EN to add a DRAIN watchdog that
// forces DONE with error_o=1 when results stop arriving.
module exp_2_ctrl
  import exp_2_ctrl_pkg::*;
#(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int timeout_cycles = 16
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [data_size-1:0]              in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [data_size-1:0]              exp_2_data_o,
  output logic                              exp_2_data_valid_o,
  input  logic [data_size-1:0]              exp_2_result_i,
  input  logic                              exp_2_result_valid_i,
  output logic [data_size-1:0]              out_data_o,
  output logic [IDX_W-1:0]                  out_index_o,
  output logic                              out_valid_o,
  output logic [data_size+SUM_GUARD_BITS-1:0] sum_o,
  output logic                              sum_valid_o,
  output logic                              busy_o,
  output logic                              error_o
);

  localparam int SUM_W = data_size + SUM_GUARD_BITS;
  // One extra bit so the counters can represent number_of_data itself.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(number_of_data - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   issue_cnt_q;
  logic [CNT_W-1:0]   ret_cnt_q;
  logic [SUM_W-1:0]   acc_q;
  logic [SUM_W-1:0]   acc_d;
  logic [SUM_W-1:0]   sum_q;
  logic               sum_valid_q;
  logic [data_size-1:0] exp_2_data_q;
  logic               exp_2_valid_q;
  logic [data_size-1:0] out_data_q;
  logic [IDX_W-1:0]   out_index_q;
  logic               out_valid_q;

  logic accept;
  logic result_take;
  logic issue_last;
  logic ret_last;

  assign accept      = in_valid_i & (state_q == ISSUE);
  assign result_take = exp_2_result_valid_i & ((state_q == ISSUE) | (state_q == DRAIN));
  assign issue_last  = accept & (issue_cnt_q == CNT_LAST);
  assign ret_last    = result_take & (ret_cnt_q == CNT_LAST);
  // Accumulator value including this cycle's result, so the final sum is
  // captured in the same edge that enters DONE.
  assign acc_d = acc_q + (result_take ? {{SUM_GUARD_BITS{1'b0}}, exp_2_result_i} : '0);

  assign in_ready_o         = (state_q == ISSUE);
  assign busy_o             = (state_q != IDLE);
  assign exp_2_data_o       = exp_2_data_q;
  assign exp_2_data_valid_o = exp_2_valid_q;
  assign out_data_o         = out_data_q;
  assign out_index_o        = out_index_q;
  assign out_valid_o        = out_valid_q;
  assign sum_o              = sum_q;
  assign sum_valid_o        = sum_valid_q;

`ifdef EXP_2_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(timeout_cycles + 1);
  logic [WD_W-1:0] wd_q;
  logic            error_q;
  logic            timeout_hit;

  assign timeout_hit = (state_q == DRAIN) & (wd_q == WD_W'(timeout_cycles - 1)) & ~ret_last;
  assign error_o     = error_q;

  // Watchdog: counts cycles spent in DRAIN, cleared in every other state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wd_q <= '0;
    end else if (state_q == DRAIN) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (timeout_cycles != 0);
  assign error_o        = 1'b0;
`endif

  // FSM plus all registered datapath outputs, counters and accumulator.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      acc_q         <= '0;
      sum_q         <= '0;
      sum_valid_q   <= 1'b0;
      exp_2_data_q  <= '0;
      exp_2_valid_q <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_valid_q   <= 1'b0;
`ifdef EXP_2_CTRL_TIMEOUT_EN
      error_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, and a later assignment to
      // the same register in this block (the FSM case below) takes priority.
      exp_2_valid_q <= accept;
      if (accept) begin
        exp_2_data_q <= in_data_i;
        issue_cnt_q  <= issue_cnt_q + 1'b1;
      end
      out_valid_q <= result_take;
      if (result_take) begin
        out_data_q  <= exp_2_result_i;
        out_index_q <= ret_cnt_q[IDX_W-1:0];
        ret_cnt_q   <= ret_cnt_q + 1'b1;
        acc_q       <= acc_d;
      end
      sum_valid_q <= 1'b0;
`ifdef EXP_2_CTRL_TIMEOUT_EN
      error_q     <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          if (start_i) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (ret_last) begin
            sum_q       <= acc_d;
            sum_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (issue_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_last) begin
            sum_q       <= acc_d;
            sum_valid_q <= 1'b1;
            state_q     <= DONE;
          end
`ifdef EXP_2_CTRL_TIMEOUT_EN
          else if (timeout_hit) begin
            sum_q       <= acc_d;
            sum_valid_q <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= DONE;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_2_ctrl.sv
// Self-checking bench for exp_2_ctrl: random samples, an external exp_2
// datapath model with 2-cycle latency, and a queue-based reference of the
// expected element stream and vector sum.
module tb_exp_2_ctrl;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int TO = 16;
  localparam int SW = DW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_index;
  logic          out_valid;
  logic [SW-1:0] sum_o;
  logic          sum_valid;
  logic          busy;
  logic          error;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exp_2_ctrl #(
    .data_size     (DW),
    .number_of_data(N),
    .timeout_cycles(TO)
  ) dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .start_i             (start),
    .in_data_i           (in_data),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .exp_2_data_o        (exp_data),
    .exp_2_data_valid_o  (exp_valid),
    .exp_2_result_i      (res_data),
    .exp_2_result_valid_i(res_valid),
    .out_data_o          (out_data),
    .out_index_o         (out_index),
    .out_valid_o         (out_valid),
    .sum_o               (sum_o),
    .sum_valid_o         (sum_valid),
    .busy_o              (busy),
    .error_o             (error)
  );

  // ---------------- exp_2 datapath model ----------------
  bit            mode_rand = 1'b0;
  bit            drop_en   = 1'b0;
  logic          v1, v2;
  logic [DW-1:0] d1, d2;
  int            res_cnt;
  logic          stray_v = 1'b0;
  logic [DW-1:0] stray_d = '0;

  function automatic logic [DW-1:0] f_exp(input logic [DW-1:0] d, input bit rnd);
    return rnd ? (d * 32'h9E37_79B1) : 32'h8000_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0; res_cnt <= 0;
    end else begin
      v1 <= exp_valid;
      d1 <= f_exp(exp_data, mode_rand);
      d2 <= d1;
      if (start && !busy) res_cnt <= 0;
      else if (v1) res_cnt <= res_cnt + 1;
      v2 <= v1 && !(drop_en && res_cnt == N - 1);
    end
  end

  assign res_valid = v2 | stray_v;
  assign res_data  = stray_v ? stray_d : d2;

  // ---------------- observation (negedge, away from active edge) ----------------
  logic [DW-1:0] in_seen[$];
  logic [DW-1:0] exp_seen[$];
  logic [DW-1:0] out_data_seen[$];
  int            out_idx_seen[$];
  int            n_sum = 0;
  int            drain_cnt = 0;
  logic [SW-1:0] last_sum = '0;
  logic          last_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) in_seen.push_back(in_data);
      if (exp_valid) exp_seen.push_back(exp_data);
      if (out_valid) begin
        out_data_seen.push_back(out_data);
        out_idx_seen.push_back(int'(out_index));
      end
      if (busy && !in_ready && !sum_valid) drain_cnt++;
      if (sum_valid) begin
        n_sum++;
        last_sum = sum_o;
        last_err = error;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("comparison %s did not hold", tag);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_ready"},  64'(in_ready),  0);
    check({pfx, "_busy"},      64'(busy),      0);
    check({pfx, "_exp_valid"}, 64'(exp_valid), 0);
    check({pfx, "_exp_data"},  64'(exp_data),  0);
    check({pfx, "_out_valid"}, 64'(out_valid), 0);
    check({pfx, "_out_data"},  64'(out_data),  0);
    check({pfx, "_out_index"}, 64'(out_index), 0);
    check({pfx, "_sum"},       64'(sum_o),     0);
    check({pfx, "_sum_valid"}, 64'(sum_valid), 0);
    check({pfx, "_error"},     64'(error),     0);
  endtask

  logic [DW-1:0] stim[16];

  task automatic clear_obs();
    in_seen.delete(); exp_seen.delete();
    out_data_seen.delete(); out_idx_seen.delete();
    drain_cnt = 0;
  endtask

  // Start one vector and keep offering samples until a sum appears or the
  // cycle budget runs out. Samples beyond N are offered too; none may be taken.
  task automatic run_vector(input bit toggle, input bit poke_start, input int budget,
                            output bit done);
    int base;
    int idx;
    bit taken;
    for (int i = 0; i < 16; i++) stim[i] = $urandom;
    clear_obs();
    base = n_sum;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < budget && n_sum == base; cyc++) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = stim[(idx < 16) ? idx : 15];
      start    = poke_start && (cyc == 3);
      taken    = in_valid && in_ready;
      @(posedge clk); #2;
      start = 1'b0;
      if (taken) idx++;
    end
    in_valid = 1'b0;
    done = (n_sum != base);
  endtask

  task automatic verify_vector(input string tag, input bit rnd);
    logic [SW-1:0] exp_sum;
    exp_sum = '0;
    check({tag, "_n_accept"}, 64'(in_seen.size()), N);
    check({tag, "_n_issue"},  64'(exp_seen.size()), N);
    check({tag, "_n_out"},    64'(out_idx_seen.size()), N);
    for (int i = 0; i < N; i++) begin
      exp_sum += {4'h0, f_exp(stim[i], rnd)};
      if (i < in_seen.size())  check({tag, "_in_order"},  64'(in_seen[i]),  64'(stim[i]));
      if (i < exp_seen.size()) check({tag, "_exp_order"}, 64'(exp_seen[i]), 64'(stim[i]));
      if (i < out_idx_seen.size()) begin
        check({tag, "_out_index"}, 64'(out_idx_seen[i]), 64'(i));
        check({tag, "_out_data"},  64'(out_data_seen[i]), 64'(f_exp(stim[i], rnd)));
      end
    end
    check({tag, "_sum"}, 64'(last_sum), 64'(exp_sum));
    check({tag, "_err"}, 64'(last_err), 0);
    @(posedge clk); #2;
    check({tag, "_sum_hold"},  64'(sum_o), 64'(exp_sum));
    check({tag, "_sum_valid"}, 64'(sum_valid), 0);
    check({tag, "_idle"},      64'(busy), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit done;
    int taken_n;
    logic [SW-1:0] prev_sum;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Fixed 0.5 results, continuous valid: expect sum 5.0.
    mode_rand = 1'b0;
    run_vector(1'b0, 1'b0, 100, done);
    check("A_done", 64'(done), 1);
    verify_vector("A", 1'b0);
    check("A_sum_const", 64'(last_sum), 64'h5_0000_0000);

    // Toggling valid.
    run_vector(1'b1, 1'b0, 100, done);
    check("B_done", 64'(done), 1);
    verify_vector("B", 1'b0);

    // Stray result beats in IDLE must be ignored.
    clear_obs();
    prev_sum = sum_o;
    for (int i = 0; i < 3; i++) begin
      stray_v = 1'b1; stray_d = $urandom;
      @(posedge clk); #2;
    end
    stray_v = 1'b0;
    @(posedge clk); #2;
    check("stray_no_out", 64'(out_idx_seen.size()), 0);
    check("stray_sum",    64'(sum_o), 64'(prev_sum));
    check("stray_busy",   64'(busy), 0);

    // Random results, start_i poked during ISSUE.
    mode_rand = 1'b1;
    run_vector(1'b0, 1'b1, 100, done);
    check("C_done", 64'(done), 1);
    verify_vector("C", 1'b1);

    run_vector(1'b1, 1'b0, 100, done);
    check("D_done", 64'(done), 1);
    verify_vector("D", 1'b1);

    // Reset after 4 accepted beats.
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    taken_n = 0;
    for (int cyc = 0; cyc < 50 && taken_n < 4; cyc++) begin
      in_valid = 1'b1; in_data = $urandom;
      if (in_ready) taken_n++;
      @(posedge clk); #2;
    end
    check("R_accepted4", 64'(taken_n), 4);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    check("R_wait_start", 64'(busy), 0);
    run_vector(1'b0, 1'b0, 100, done);
    check("E_done", 64'(done), 1);
    verify_vector("E", 1'b1);

    // Dropped 10th result.
    mode_rand = 1'b0;
    drop_en   = 1'b1;
`ifdef EXP_2_CTRL_TIMEOUT_EN
    run_vector(1'b0, 1'b0, 100, done);
    check("T_done",      64'(done), 1);
    check("T_err",       64'(last_err), 1);
    check("T_sum",       64'(last_sum), 64'h4_8000_0000);
    check("T_drain_cyc", 64'(drain_cnt), TO);
    check("T_n_out",     64'(out_idx_seen.size()), N - 1);
    @(posedge clk); #2;
    check("T_err_pulse", 64'(error), 0);
    check("T_idle",      64'(busy), 0);
`else
    run_vector(1'b0, 1'b0, 60, done);
    check("T_no_done",  64'(done), 0);
    check("T_busy",     64'(busy), 1);
    check("T_in_ready", 64'(in_ready), 0);
    check("T_err",      64'(error), 0);
    check("T_n_out",    64'(out_idx_seen.size()), N - 1);
    rst = 1'b1;
    #1;
    check_all_zero("T_reset");
    @(posedge clk); #2 rst = 1'b0;
`endif
    drop_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
